// File: rtl/rom_ctrl_pkg.sv
// Shared encodings for the ROM access sequencer.
// State and owner codes are sparse so a flipped bit lands on an illegal code.
package rom_ctrl_pkg;

   localparam int unsigned EncW = 5;

   typedef enum logic [EncW-1:0] {
      SeqSweep = 5'b00111,
      SeqDone  = 5'b11001,
      SeqError = 5'b11110
   } seq_state_e;

   typedef enum logic [EncW-1:0] {
      OwnNone  = 5'b00000,
      OwnSweep = 5'b00111,
      OwnBus   = 5'b11001
   } owner_e;

endpackage

// File: rtl/prim_flop.sv
// Plain resettable register used for every sequencer state register.
// Keeping these in one primitive makes them easy to find and harden.
module prim_flop #(
   parameter int unsigned      Width      = 1,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_o <= ResetValue;
      end else begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/rom_ctrl_access_seq.sv
// ROM access sequencer: post-reset digest sweep, then bus reads.
// ROM_CTRL_SWEEP_BUS_SHARE_EN lets the bus share the ROM during the sweep.
module rom_ctrl_access_seq
   import rom_ctrl_pkg::*;
#(
   parameter int unsigned Width = 40,
   parameter int unsigned Depth = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     bus_req_i,
   input  logic [$clog2(Depth)-1:0] bus_addr_i,
   output logic                     bus_gnt_o,
   output logic                     bus_rvalid_o,
   output logic [Width-1:0]         bus_rdata_o,
   output logic                     rom_req_o,
   output logic [$clog2(Depth)-1:0] rom_addr_o,
   input  logic                     rom_rvalid_i,
   input  logic [Width-1:0]         rom_scr_rdata_i,
   input  logic [Width-1:0]         rom_clr_rdata_i,
   output logic                     hash_valid_o,
   output logic [Width-1:0]         hash_data_o,
   output logic                     hash_last_o,
   input  logic                     hash_ready_i,
   output logic                     done_o,
   output logic                     alert_o
);

   localparam int unsigned    Aw     = $clog2(Depth);
   localparam int unsigned    Cw     = Aw + 1;
   localparam logic [Cw-1:0]  CntEnd = Cw'(Depth);

   logic [EncW-1:0]  state_d, state_q;
   logic [EncW-1:0]  owner_d, owner_q;
   logic [Cw-1:0]    cnt_d, cnt_q;

   logic             hold_vld_q;
   logic             hold_last_q;
   logic [Width-1:0] hold_data_q;

   logic st_sweep, st_done, st_error, st_bad;
   logic own_none, own_sweep, own_bus, own_bad;
   logic proto_err, go_err, bus_ok;
   logic sweep_issue, hash_fire, sweep_rvalid, last_accept;

   prim_flop #(
      .Width      (EncW),
      .ResetValue (SeqSweep)
   ) u_state_flop (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (state_d),
      .q_o    (state_q)
   );

   prim_flop #(
      .Width      (EncW),
      .ResetValue (OwnNone)
   ) u_owner_flop (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (owner_d),
      .q_o    (owner_q)
   );

   prim_flop #(
      .Width      (Cw),
      .ResetValue ('0)
   ) u_cnt_flop (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (cnt_d),
      .q_o    (cnt_q)
   );

   always_comb begin
      st_sweep = 1'b0;
      st_done  = 1'b0;
      st_error = 1'b0;
      st_bad   = 1'b0;
      unique case (state_q)
         SeqSweep: st_sweep = 1'b1;
         SeqDone:  st_done  = 1'b1;
         SeqError: st_error = 1'b1;
         default:  st_bad   = 1'b1;
      endcase
   end

   always_comb begin
      own_none  = 1'b0;
      own_sweep = 1'b0;
      own_bus   = 1'b0;
      own_bad   = 1'b0;
      unique case (owner_q)
         OwnNone:  own_none  = 1'b1;
         OwnSweep: own_sweep = 1'b1;
         OwnBus:   own_bus   = 1'b1;
         default:  own_bad   = 1'b1;
      endcase
   end

   // The ROM answers exactly one cycle after a request, never otherwise.
   assign proto_err = (own_none & rom_rvalid_i)
                    | ((own_sweep | own_bus) & ~rom_rvalid_i);
   assign go_err    = proto_err | st_error | st_bad | own_bad;

`ifdef ROM_CTRL_SWEEP_BUS_SHARE_EN
   assign bus_ok = st_sweep | st_done;
`else
   assign bus_ok = st_done;
`endif

   assign bus_gnt_o    = bus_ok & bus_req_i & own_none;

   assign hash_valid_o = hold_vld_q & st_sweep;
   assign hash_fire    = hash_valid_o & hash_ready_i;
   assign hash_last_o  = hash_valid_o & hold_last_q;
   assign hash_data_o  = hold_data_q;
   assign last_accept  = hash_fire & hold_last_q;

   assign sweep_issue = st_sweep & own_none & ~bus_gnt_o
                      & (~hold_vld_q | hash_fire)
                      & (cnt_q != CntEnd);

   assign rom_req_o  = bus_gnt_o | sweep_issue;
   assign rom_addr_o = bus_gnt_o   ? bus_addr_i :
                       sweep_issue ? cnt_q[Aw-1:0] : '0;

   assign bus_rvalid_o = rom_rvalid_i & own_bus;
   assign bus_rdata_o  = bus_rvalid_o ? rom_clr_rdata_i : '0;
   assign sweep_rvalid = rom_rvalid_i & own_sweep;

   assign done_o  = st_done;
   assign alert_o = st_error;

   assign cnt_d = cnt_q + Cw'(sweep_issue);

   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         go_err:                 state_d = SeqError;
         !go_err && last_accept: state_d = SeqDone;
         default:                state_d = state_q;
      endcase
   end

   always_comb begin
      owner_d = OwnNone;
      if (!go_err) begin
         if (bus_gnt_o) begin
            owner_d = OwnBus;
         end else if (sweep_issue) begin
            owner_d = OwnSweep;
         end
      end
   end

   // The counter is already past the word when its data returns.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_vld_q  <= 1'b0;
         hold_last_q <= 1'b0;
         hold_data_q <= '0;
      end else if (sweep_rvalid) begin
         hold_vld_q  <= 1'b1;
         hold_last_q <= (cnt_q == CntEnd);
         hold_data_q <= rom_scr_rdata_i;
      end else if (hash_fire) begin
         hold_vld_q  <= 1'b0;
         hold_last_q <= 1'b0;
      end
   end

endmodule
